// File: rtl/ibex_csr_access_seq.sv
// ibex_csr_access_seq: sequences one read-modify-write access to a CSR primitive
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o    request handshake; req_addr_i, req_op_i, req_wdata_i
//                          (op: 00 read, 01 write, 10 set, 11 clear)
//   rsp_valid_o/ready_i    response handshake; rsp_rdata_o (value before access),
//                          rsp_error_o
//   csr_addr_o, csr_wr_en_o, csr_wr_data_o, csr_mstatus_en_o   CSR primitive controls
//   csr_rd_data_i, csr_rd_error_i                              CSR primitive read side
//   err_cnt_o              saturating count of errored responses
module ibex_csr_access_seq #(
    parameter int unsigned Width       = 32,
    parameter logic [11:0] MstatusAddr = 12'h300
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [11:0]      req_addr_i,
    input  logic [1:0]       req_op_i,
    input  logic [Width-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_error_o,
    output logic [11:0]      csr_addr_o,
    output logic             csr_wr_en_o,
    output logic [Width-1:0] csr_wr_data_o,
    output logic             csr_mstatus_en_o,
    input  logic [Width-1:0] csr_rd_data_i,
    input  logic             csr_rd_error_i,
    output logic [7:0]       err_cnt_o
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] CHK  = 3'd3;
    localparam logic [2:0] RSP  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [11:0]      addr_q;
    logic [1:0]       op_q;
    logic [Width-1:0] wdata_q, old_q;
    logic             err_q;
    logic [7:0]       err_cnt_q;
    logic             illegal, no_write, hs;

    // Top two address bits 11 mark read-only CSRs; any modifying op is illegal.
    assign illegal  = (op_q != 2'b00) && (addr_q[11:10] == 2'b11);
    // A read-side error during RD also suppresses the write.
    assign no_write = (op_q == 2'b00) || (op_q[1] && (wdata_q == '0)) || illegal || csr_rd_error_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req_valid_i ? RD : IDLE;
            RD:      state_d = no_write ? RSP : WR;
            WR:      state_d = CHK;
            CHK:     state_d = RSP;
            RSP:     state_d = rsp_ready_i ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o      = state_q == IDLE;
    assign csr_addr_o       = (state_q == RD || state_q == WR || state_q == CHK) ? addr_q : 12'h000;
    assign csr_wr_en_o      = state_q == WR;
    assign csr_mstatus_en_o = csr_wr_en_o && (addr_q == MstatusAddr);
    assign csr_wr_data_o    = !csr_wr_en_o      ? '0 :
                              op_q == 2'b01     ? wdata_q :
                              op_q == 2'b10     ? (old_q | wdata_q) : (old_q & ~wdata_q);
    assign rsp_valid_o      = state_q == RSP;
    assign rsp_rdata_o      = rsp_valid_o ? old_q : '0;
    assign rsp_error_o      = rsp_valid_o && (err_q || illegal);
    assign hs               = rsp_valid_o && rsp_ready_i;
    assign err_cnt_o        = err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= 12'h000;
            op_q      <= 2'b00;
            wdata_q   <= '0;
            old_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid_i) begin
                addr_q  <= req_addr_i;
                op_q    <= req_op_i;
                wdata_q <= req_wdata_i;
            end
            if (state_q == RD) begin
                old_q <= csr_rd_data_i;
                err_q <= csr_rd_error_i;
            end
            if (state_q == CHK) err_q <= err_q | csr_rd_error_i;
            if (hs && rsp_error_o && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_ibex_csr_access_seq.sv
// tb_ibex_csr_access_seq: randomized self-checking bench for ibex_csr_access_seq
module tb_ibex_csr_access_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_addr = 12'h000;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [11:0] csr_addr;
    logic        csr_wr_en;
    logic [31:0] csr_wr_data;
    logic        csr_mst;
    logic [31:0] rd_data = 32'h0;
    logic        rd_err = 1'b0;
    logic [7:0]  err_cnt;
    int total = 0;
    int bad = 0;
    int cnt = 0;

    ibex_csr_access_seq dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_op_i(req_op), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_error_o(rsp_error),
        .csr_addr_o(csr_addr), .csr_wr_en_o(csr_wr_en), .csr_wr_data_o(csr_wr_data),
        .csr_mstatus_en_o(csr_mst), .csr_rd_data_i(rd_data), .csr_rd_error_i(rd_err),
        .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    // One complete access: expected behaviour is derived directly from the access rules.
    // Cycle k after acceptance: 1 = read phase, 3 = check phase of a write.
    task automatic do_access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                             input logic [31:0] old, input logic err_rd, input logic err_chk, input int hold);
        logic ill, nowr, exp_err, vseen, mst;
        logic [31:0] exp_wd, wd;
        int lat, k, wr_n;
        ill     = op != 2'b00 && addr[11:10] == 2'b11;
        nowr    = op == 2'b00 || (op[1] && wdata == 32'h0) || ill || err_rd;
        exp_wd  = op == 2'b01 ? wdata : op == 2'b10 ? (old | wdata) : (old & ~wdata);
        exp_err = ill || err_rd || (!nowr && err_chk);
        lat     = nowr ? 2 : 4;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_idle got=%b exp=1", req_ready); end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        rd_data = old; rd_err = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'($urandom_range(0, 1)); req_op = 2'($urandom); req_addr = 12'($urandom); req_wdata = $urandom;
        rd_err = err_rd;
        wr_n = 0; wd = 32'h0; mst = 1'b0; vseen = 1'b0; k = 1;
        while (!vseen && k <= 8) begin
            @(negedge clk);
            if (k == 1) begin
                total++;
                if (csr_addr !== addr) begin bad++; $display("FAIL csr_addr got=%h exp=%h", csr_addr, addr); end
            end
            if (csr_wr_en) begin
                wr_n++; wd = csr_wr_data; mst = csr_mst;
            end else begin
                total++;
                if (csr_wr_data !== 32'h0 || csr_mst !== 1'b0) begin
                    bad++; $display("FAIL wr_data_idle got=%h mst=%b exp=0", csr_wr_data, csr_mst);
                end
            end
            if (rsp_valid) vseen = 1'b1;
            else begin
                k++;
                @(posedge clk); #1;
                rd_err = (k == 3) && err_chk;
            end
        end
        rd_err = 1'b0;
        total++;
        if (k !== lat) begin bad++; $display("FAIL latency got=%0d exp=%0d op=%b addr=%h", k, lat, op, addr); end
        total++;
        if (wr_n !== (nowr ? 0 : 1)) begin bad++; $display("FAIL wr_pulses got=%0d exp=%0d", wr_n, nowr ? 0 : 1); end
        if (!nowr) begin
            total++;
            if (wd !== exp_wd) begin bad++; $display("FAIL wr_data got=%h exp=%h", wd, exp_wd); end
        end
        total++;
        if (mst !== (!nowr && addr == 12'h300)) begin bad++; $display("FAIL mstatus_en got=%b exp=%b", mst, !nowr && addr == 12'h300); end
        total++;
        if (rsp_rdata !== old) begin bad++; $display("FAIL rsp_rdata got=%h exp=%h", rsp_rdata, old); end
        total++;
        if (rsp_error !== exp_err) begin bad++; $display("FAIL rsp_error got=%b exp=%b", rsp_error, exp_err); end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            req_valid = 1'($urandom_range(0, 1)); req_addr = 12'($urandom); req_op = 2'($urandom);
            @(negedge clk);
            total++;
            if ({rsp_valid, rsp_rdata, rsp_error, req_ready} !== {1'b1, old, exp_err, 1'b0}) begin
                bad++; $display("FAIL rsp_hold got=%b/%h/%b/%b exp=1/%h/%b/0", rsp_valid, rsp_rdata, rsp_error, req_ready, old, exp_err);
            end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (exp_err && cnt != 255) cnt++;
        @(negedge clk);
        total++;
        if ({err_cnt, rsp_valid, rsp_rdata, rsp_error, req_ready} !== {8'(cnt), 1'b0, 32'h0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL after_hs got cnt=%0d v=%b d=%h e=%b rdy=%b exp cnt=%0d 0/0/0/1", err_cnt, rsp_valid, rsp_rdata, rsp_error, req_ready, cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_op = 2'b01; req_addr = 12'h300;
        repeat (3) @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, rsp_error, csr_wr_en, csr_mst, csr_addr, csr_wr_data, rsp_rdata, err_cnt} !==
            {1'b1, 4'b0, 12'h0, 32'h0, 32'h0, 8'h0}) begin
            bad++; $display("FAIL reset_outputs got rdy=%b v=%b e=%b we=%b m=%b a=%h wd=%h rd=%h c=%h", req_ready, rsp_valid,
                            rsp_error, csr_wr_en, csr_mst, csr_addr, csr_wr_data, rsp_rdata, err_cnt);
        end
        req_valid = 1'b0; rst_n = 1'b1; cnt = 0;
    endtask

    task automatic test_read();
        do_access(2'b00, 12'h341, 32'h1234_5678, 32'hA5A5_0000, 1'b0, 1'b0, 0);
    endtask

    task automatic test_set();
        do_access(2'b10, 12'h300, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_noop_illegal();
        do_access(2'b11, 12'h341, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
        do_access(2'b01, 12'hC00, 32'h5555_AAAA, 32'h0000_1111, 1'b0, 1'b0, 0);
        total++;
        if (err_cnt !== 8'd1) begin bad++; $display("FAIL illegal_err_cnt got=%0d exp=1", err_cnt); end
    endtask

    task automatic test_shadow_error();
        do_access(2'b01, 12'h305, $urandom, $urandom, 1'b0, 1'b1, 3);
    endtask

    task automatic test_reset_mid_write();
        int v;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_addr = 12'h300; req_wdata = 32'hCAFE_F00D; rd_data = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (csr_wr_en !== 1'b1) begin bad++; $display("FAIL wr_before_reset got=%b exp=1", csr_wr_en); end
        rst_n = 1'b0; #1;
        cnt = 0;
        total++;
        if ({csr_wr_en, csr_mst, req_ready, rsp_valid, err_cnt, csr_addr, csr_wr_data} !== {3'b001, 1'b0, 8'h0, 12'h0, 32'h0}) begin
            bad++; $display("FAIL async_reset got we=%b m=%b rdy=%b v=%b c=%h a=%h wd=%h exp 0/0/1/0/0/0/0", csr_wr_en, csr_mst,
                            req_ready, rsp_valid, err_cnt, csr_addr, csr_wr_data);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (csr_wr_en !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL post_reset_quiet got we=%b v=%b exp 0/0", csr_wr_en, rsp_valid); end
        end
        rst_n = 1'b0; req_valid = 1'b1; req_op = 2'b00; req_addr = 12'h341;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if (csr_addr !== 12'h341 || req_ready !== 1'b0) begin bad++; $display("FAIL first_accept got a=%h rdy=%b exp 341/0", csr_addr, req_ready); end
        rsp_ready = 1'b1;
        v = 0;
        for (int i = 0; i < 4 && !req_ready; i++) begin @(posedge clk); #1; v++; end
        rsp_ready = 1'b0;
        total++;
        if (req_ready !== 1'b1 || v !== 2) begin bad++; $display("FAIL first_complete got rdy=%b cycles=%0d exp 1/2", req_ready, v); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++)
            do_access(2'($urandom_range(0, 3)),
                      $urandom_range(0, 3) == 0 ? 12'h300 : 12'($urandom),
                      $urandom_range(0, 4) == 0 ? 32'h0 : $urandom,
                      $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3));
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++)
            do_access(2'($urandom_range(1, 3)), {2'b11, 10'($urandom)}, $urandom | 32'h1, $urandom, 1'b0, 1'b0, 0);
        total++;
        if (err_cnt !== 8'hFF) begin bad++; $display("FAIL err_cnt_saturate got=%h exp=ff", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_set();
        test_noop_illegal();
        test_shadow_error();
        test_reset_mid_write();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ibex_csr_access_seq.md
IBEX_CSR_ACCESS_SEQ -- requirements
Module: ibex_csr_access_seq

Interface
REQ-001 Parameter Width, default 32: data width of the CSR data path.
REQ-002 Parameter MstatusAddr, default 12'h300: address that asserts csr_mstatus_en_o.
REQ-003 clk_i  input  1  clock, rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  1  access request valid.
REQ-006 req_ready_o  output  1  sequencer can accept a request.
REQ-007 req_addr_i  input  12  CSR address.
REQ-008 req_op_i  input  2  operation: 00 read, 01 write, 10 set, 11 clear.
REQ-009 req_wdata_i  input  Width  operand for write, set or clear.
REQ-010 rsp_valid_o  output  1  response valid.
REQ-011 rsp_ready_i  input  1  response consumer ready.
REQ-012 rsp_rdata_o  output  Width  CSR value before the access.
REQ-013 rsp_error_o  output  1  access failed.
REQ-014 csr_addr_o  output  12  address of the CSR being accessed.
REQ-015 csr_wr_en_o  output  1  one-cycle write strobe to the CSR primitive.
REQ-016 csr_wr_data_o  output  Width  write data to the CSR primitive.
REQ-017 csr_mstatus_en_o  output  1  the access targets MstatusAddr.
REQ-018 csr_rd_data_i  input  Width  CSR primitive read data.
REQ-019 csr_rd_error_i  input  1  CSR primitive shadow-mismatch error.
REQ-020 err_cnt_o  output  8  saturating count of errored responses.

Function
REQ-021 The FSM SHALL have states IDLE, RD, WR, CHK and RSP; reset state is IDLE.
REQ-022 IDLE: req_ready_o=1 and all other state outputs are 0; on req_valid_i, the block SHALL latch addr, op and wdata and move to RD. req_ready_o SHALL be 0 in every other state.
REQ-023 csr_addr_o SHALL equal the latched address in RD, WR and CHK, and 0 in IDLE and RSP.
REQ-024 csr_mstatus_en_o SHALL be 1 only in WR, and only when the latched address equals MstatusAddr.
REQ-025 RD: the block SHALL sample csr_rd_data_i into old_q and csr_rd_error_i into err_q.
REQ-026 An access is illegal when the op is not read and addr[11:10]==2'b11.
REQ-027 No-write condition: op is read; or op is set/clear with wdata==0; or the access is illegal; or csr_rd_error_i=1 in RD.
REQ-028 RD -> RSP when the no-write condition holds; otherwise RD -> WR.
REQ-029 WR: csr_wr_en_o=1 for exactly this one cycle, then WR -> CHK unconditionally.
REQ-030 csr_wr_data_o SHALL be wdata for write, old_q|wdata for set, and old_q&~wdata for clear. It is valid only while csr_wr_en_o=1 and SHALL be 0 otherwise.
REQ-031 CHK: the block SHALL OR csr_rd_error_i into err_q, then CHK -> RSP.
REQ-032 RSP: rsp_valid_o=1, rsp_rdata_o=old_q, rsp_error_o=err_q|illegal. These values SHALL hold stable until rsp_ready_i=1.
REQ-033 RSP -> IDLE on rsp_ready_i=1. rsp_rdata_o and rsp_error_o SHALL be 0 whenever rsp_valid_o=0.
REQ-034 Latency, request accepted at edge T:
- read or no-write access: rsp_valid_o rises after edge T+2;
- write-class access: rsp_valid_o rises after edge T+4.
REQ-035 Throughput: at most one access is in flight. A new request is accepted no earlier than the cycle after the response handshake.
REQ-036 err_cnt_o SHALL increment by 1 on each response handshake with rsp_error_o=1 and SHALL saturate at 8'hFF.
REQ-037 Input changes on req_* SHALL be ignored outside IDLE.

Reset
REQ-038 Asserting rst_ni low at any time SHALL asynchronously force the following:
- state = IDLE;
- req_ready_o = 1;
- rsp_valid_o, rsp_error_o, csr_wr_en_o, csr_mstatus_en_o = 0;
- csr_addr_o, csr_wr_data_o, rsp_rdata_o = 0;
- err_cnt_o = 0.
REQ-039 A reset in WR SHALL drop csr_wr_en_o in the same cycle, and no write SHALL be issued after release.
REQ-040 The first request after reset release SHALL be acceptable at the first rising edge with rst_ni=1.

Verification
REQ-041 Read: csr_rd_data_i=32'hA5A5_0000, op=00, addr=12'h341 -> rsp_rdata_o=32'hA5A5_0000, error=0, csr_wr_en_o never 1, rsp_valid_o 2 cycles after accept.
REQ-042 Set: old value 32'h0000_00F0, op=10, wdata=32'h0000_000F, addr=12'h300 -> one csr_wr_en_o pulse with data 32'h0000_00FF and csr_mstatus_en_o=1; rsp_rdata_o=32'h0000_00F0; rsp_valid_o 4 cycles after accept.
REQ-043 Clear with zero operand and illegal write: op=11 wdata=0 -> no write, error=0. Then op=01 addr=12'hC00 -> no write, error=1, err_cnt_o=1.
REQ-044 Shadow error: csr_rd_error_i=1 only in the CHK cycle of a write -> rsp_error_o=1. With rsp_ready_i=0 for 3 cycles, the response holds stable and req_ready_o stays 0.
REQ-045 Reset mid-write: rst_ni low in the WR cycle -> csr_wr_en_o=0 at once, err_cnt_o=0, req_ready_o=1, and no response after release.
REQ-046 Saturation: 260 errored responses -> err_cnt_o=8'hFF.
